// File: rtl/color_sensor_pkg.sv
// color_sensor_pkg: shared FSM encoding, class codes and sensor address constants for the colour path.
package color_sensor_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PERIOD,
    S_REQ,
    S_RELEASE,
    S_NEXT,
    S_CLASSIFY,
    S_PUBLISH,
    S_ABORT
  } state_e;

  localparam logic [1:0] CLS_NONE  = 2'd0;
  localparam logic [1:0] CLS_RED   = 2'd1;
  localparam logic [1:0] CLS_GREEN = 2'd2;
  localparam logic [1:0] CLS_BLUE  = 2'd3;

  localparam logic [6:0] DEV_ADDR_DEF  = 7'h29;
  localparam logic [7:0] CDATA_REG_DEF = 8'h94;

  // Each channel is a 16-bit register pair, so channels sit two addresses apart.
  function automatic logic [7:0] chan_reg(input logic [7:0] base, input logic [1:0] idx);
    return base + {5'd0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/color_frame_sequencer_if.sv
// color_frame_sequencer_if: 2-byte I2C read request/response bundle between sequencer (master) and I2C engine (slave).
interface color_frame_sequencer_if;
  logic        start;
  logic [6:0]  dev_addr;
  logic [7:0]  reg_addr;
  logic [15:0] data;
  logic        busy;
  logic        done;
  modport master (output start, dev_addr, reg_addr, input data, busy, done);
  modport slave  (input start, dev_addr, reg_addr, output data, busy, done);
endinterface

// File: rtl/color_classifier.sv
// color_classifier: dominant-colour decision (dark below threshold, else max of R/G/B with R>G>B tie priority); used under COLOR_CLASSIFY_EN.
module color_classifier
  import color_sensor_pkg::*;
(
  input  logic [15:0] clear_i,
  input  logic [15:0] red_i,
  input  logic [15:0] green_i,
  input  logic [15:0] blue_i,
  input  logic [15:0] dark_thresh_i,
  output logic [1:0]  cls_o
);
  assign cls_o = clear_i < dark_thresh_i                  ? CLS_NONE  :
                 (red_i >= green_i && red_i >= blue_i)    ? CLS_RED   :
                 green_i >= blue_i                        ? CLS_GREEN : CLS_BLUE;
endmodule

// File: rtl/color_frame_sequencer.sv
// color_frame_sequencer: periodic C/R/G/B 16-bit read sequencer with per-read timeout and frame publish.
// Optional classifier enabled by defining COLOR_CLASSIFY_EN; otherwise color_class is tied to CLS_NONE.
module color_frame_sequencer
  import color_sensor_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR       = DEV_ADDR_DEF,
  parameter logic [7:0]  CDATA_REG      = CDATA_REG_DEF,
  parameter int unsigned PERIOD_CYCLES  = 2_500_000,
  parameter int unsigned TIMEOUT_CYCLES = 200_000,
  parameter logic [15:0] DARK_THRESH    = 16'd64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  color_frame_sequencer_if.master        i2c,
  output logic [15:0]                    clear_o,
  output logic [15:0]                    red_o,
  output logic [15:0]                    green_o,
  output logic [15:0]                    blue_o,
  output logic [1:0]                     color_class,
  output logic                           sample_valid,
  output logic                           error
);
  // Loaded in PUBLISH/ABORT so the next REQ lands exactly PERIOD_CYCLES later.
  localparam logic [31:0] PER_LOAD = 32'(PERIOD_CYCLES - 2);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic [15:0] shadow_q [4];
  logic [15:0] shadow_d [4];
  logic [15:0] frame_q [4];
  logic [15:0] frame_d [4];
  logic [31:0] tmo_q, tmo_d, per_q, per_d;
  logic        sv_q, sv_d;
  logic        tmo_hit;
  logic        unused_ok;

  // The counter keeps running from REQ into RELEASE, so >= also covers a late RELEASE.
  assign tmo_hit = tmo_q >= TMO_LAST;

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    shadow_d = shadow_q;
    frame_d  = frame_q;
    per_d    = per_q;
    tmo_d    = (state_q == S_REQ || state_q == S_RELEASE) ? tmo_q + 32'd1 : '0;
    sv_d     = state_q == S_PUBLISH;
    case (state_q)
      S_IDLE: if (enable) begin
        ch_d    = '0;
        state_d = S_REQ;
      end
      S_WAIT_PERIOD: if (!enable) state_d = S_IDLE;
        else if (per_q == '0) begin
          ch_d    = '0;
          state_d = S_REQ;
        end else per_d = per_q - 32'd1;
      S_REQ: if (i2c.done) begin
        shadow_d[ch_q] = i2c.data;
        state_d        = S_RELEASE;
      end else if (tmo_hit) state_d = S_ABORT;
      S_RELEASE: state_d = !i2c.done ? S_NEXT : tmo_hit ? S_ABORT : S_RELEASE;
      S_NEXT: if (ch_q == 2'd3) state_d = S_CLASSIFY;
        else begin
          ch_d    = ch_q + 2'd1;
          state_d = S_REQ;
        end
      S_CLASSIFY: state_d = S_PUBLISH;
      S_PUBLISH: begin
        frame_d = shadow_q;
        per_d   = PER_LOAD;
        state_d = S_WAIT_PERIOD;
      end
      S_ABORT: begin
        per_d   = PER_LOAD;
        state_d = S_WAIT_PERIOD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      shadow_q <= '{default: '0};
      frame_q  <= '{default: '0};
      tmo_q    <= '0;
      per_q    <= '0;
      sv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      shadow_q <= shadow_d;
      frame_q  <= frame_d;
      tmo_q    <= tmo_d;
      per_q    <= per_d;
      sv_q     <= sv_d;
    end
  end

  assign i2c.start    = state_q == S_REQ;
  assign i2c.dev_addr = DEV_ADDR;
  assign i2c.reg_addr = chan_reg(CDATA_REG, ch_q);
  assign clear_o      = frame_q[0];
  assign red_o        = frame_q[1];
  assign green_o      = frame_q[2];
  assign blue_o       = frame_q[3];
  assign sample_valid = sv_q;
  assign error        = state_q == S_ABORT;

`ifdef COLOR_CLASSIFY_EN
  logic [1:0] cls_w, cls_pend_q, cls_pend_d, cls_q, cls_d;

  color_classifier u_classifier (
    .clear_i      (shadow_q[0]),
    .red_i        (shadow_q[1]),
    .green_i      (shadow_q[2]),
    .blue_i       (shadow_q[3]),
    .dark_thresh_i(DARK_THRESH),
    .cls_o        (cls_w)
  );

  always_comb begin
    cls_pend_d = state_q == S_CLASSIFY ? cls_w : cls_pend_q;
    cls_d      = state_q == S_PUBLISH ? cls_pend_q : cls_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_pend_q <= CLS_NONE;
      cls_q      <= CLS_NONE;
    end else begin
      cls_pend_q <= cls_pend_d;
      cls_q      <= cls_d;
    end
  end

  assign color_class = cls_q;
  assign unused_ok   = i2c.busy;
`else
  assign color_class = CLS_NONE;
  assign unused_ok   = ^{i2c.busy, DARK_THRESH};
`endif

endmodule

// File: tb/tb_color_frame_sequencer.sv
// tb_color_frame_sequencer: behavioural I2C master model plus frame/address scoreboards for color_frame_sequencer.
module tb_color_frame_sequencer;
  import color_sensor_pkg::*;

  localparam int P = 60;
  localparam int T = 40;
  localparam int N = 3;
`ifdef COLOR_CLASSIFY_EN
  localparam bit CLS_ON = 1'b1;
`else
  localparam bit CLS_ON = 1'b0;
`endif

  typedef struct {
    logic [15:0] c, r, g, b;
    logic [1:0]  cls;
  } frame_t;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [15:0] c_o, r_o, g_o, b_o;
  logic [1:0]  cls;
  logic        sv, err;

  color_frame_sequencer_if bus ();

  color_frame_sequencer #(.PERIOD_CYCLES(P), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .enable(enable), .i2c(bus),
    .clear_o(c_o), .red_o(r_o), .green_o(g_o), .blue_o(b_o),
    .color_class(cls), .sample_valid(sv), .error(err)
  );

  initial forever #5 clk = ~clk;

  frame_t      exp_q[$];
  logic [7:0]  addr_q[$];
  frame_t      last = '{c: 16'd0, r: 16'd0, g: 16'd0, b: 16'd0, cls: 2'd0};
  logic [15:0] mdata [4] = '{16'd0, 16'd0, 16'd0, 16'd0};
  logic [7:0]  stall = 8'h00;
  int checks = 0, errors = 0, cyc = 0, sv_cnt = 0, err_cnt = 0;
  int last_rise = 0, exp_restart = -1;
  bit err_expected = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h at cycle %0d", name, act, want, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Master model: answers N ticks after start rises, drops done two ticks after start falls.
  initial begin
    logic       prev_start;
    logic [7:0] prev_addr, off;
    int         cnt, rel;
    prev_start = 1'b0; prev_addr = 8'h00; cnt = 0; rel = 0;
    bus.done = 1'b0; bus.data = 16'h0; bus.busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.done = 1'b0; cnt = 0; rel = 0; prev_start = 1'b0;
      end else begin
        if (bus.start && !prev_start) begin
          chk("hs_done_low_at_start", {31'd0, bus.done}, 32'd0);
          if (addr_q.size() == 0) fail("unexpected_read");
          else chk("read_addr", {24'd0, bus.reg_addr}, {24'd0, addr_q.pop_front()});
          last_rise = cyc;
          if (exp_restart >= 0) begin
            chk("restart_gap", cyc, exp_restart);
            exp_restart = -1;
          end
        end
        if (bus.start && prev_start) chk("addr_stable", {24'd0, bus.reg_addr}, {24'd0, prev_addr});
        if (bus.start) begin
          cnt++;
          rel = 0;
          if (cnt >= N && bus.reg_addr != stall) begin
            off = bus.reg_addr - 8'h94;
            bus.data = mdata[off[2:1]];
            bus.done = 1'b1;
          end
        end else begin
          cnt = 0;
          if (bus.done) begin
            rel++;
            if (rel >= 2) begin bus.done = 1'b0; rel = 0; end
          end
        end
        prev_start = bus.start;
        prev_addr  = bus.reg_addr;
      end
      bus.busy = bus.start || bus.done;
    end
  end

  // Output monitor: pops the frame scoreboard on sample_valid, validates error pulses.
  initial begin
    frame_t e;
    forever begin
      @(negedge clk);
      if (sv) begin
        sv_cnt++;
        if (exp_q.size() == 0) fail("unexpected_sample_valid");
        else begin
          e = exp_q.pop_front();
          chk("clear_o", {16'd0, c_o}, {16'd0, e.c});
          chk("red_o",   {16'd0, r_o}, {16'd0, e.r});
          chk("green_o", {16'd0, g_o}, {16'd0, e.g});
          chk("blue_o",  {16'd0, b_o}, {16'd0, e.b});
          chk("color_class", {30'd0, cls}, {30'd0, e.cls});
          last = e;
        end
      end
      if (err) begin
        err_cnt++;
        if (!err_expected) fail("unexpected_error");
        else begin
          err_expected = 1'b0;
          chk("tmo_latency", cyc - last_rise, T);
          chk("start_low_on_error", {31'd0, bus.start}, 32'd0);
          chk("clear_kept", {16'd0, c_o}, {16'd0, last.c});
          chk("red_kept",   {16'd0, r_o}, {16'd0, last.r});
          chk("blue_kept",  {16'd0, b_o}, {16'd0, last.b});
          exp_restart = cyc + P;
        end
      end
    end
  end

  task automatic push_addrs(input int n);
    for (int i = 0; i < n; i++) addr_q.push_back(8'h94 + 8'(2 * i));
  endtask

  task automatic set_frame(input logic [15:0] c, r, g, b, input logic [1:0] k);
    mdata = '{c, r, g, b};
    exp_q.push_back('{c: c, r: r, g: g, b: b, cls: CLS_ON ? k : CLS_NONE});
    push_addrs(4);
  endtask

  task automatic wait_sv(input int n);
    int k = 0;
    while (sv_cnt < n && k < 2000) begin @(negedge clk); #1; k++; end
    chk("sample_valid_count", sv_cnt, n);
  endtask

  task automatic wait_read(input logic [7:0] a);
    int k = 0;
    while (!(bus.start && bus.reg_addr == a) && k < 4 * P) begin @(negedge clk); #1; k++; end
    chk("reached_read", {31'd0, bus.start}, 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_start", {31'd0, bus.start}, 32'd0);
    chk("rst_reg_addr", {24'd0, bus.reg_addr}, 32'h94);
    chk("rst_dev_addr", {25'd0, bus.dev_addr}, 32'h29);
    chk("rst_clear", {16'd0, c_o}, 32'd0);
    chk("rst_red", {16'd0, r_o}, 32'd0);
    chk("rst_green", {16'd0, g_o}, 32'd0);
    chk("rst_blue", {16'd0, b_o}, 32'd0);
    chk("rst_class", {30'd0, cls}, 32'd0);
    chk("rst_sample_valid", {31'd0, sv}, 32'd0);
    chk("rst_error", {31'd0, err}, 32'd0);
    @(negedge clk); #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("idle_no_start", {31'd0, bus.start}, 32'd0);

    set_frame(16'd1000, 16'd600, 16'd200, 16'd100, CLS_RED);
    enable = 1'b1;
    wait_sv(1);
    set_frame(16'd40, 16'd30, 16'd20, 16'd10, CLS_NONE);
    wait_sv(2);
    set_frame(16'd500, 16'd300, 16'd300, 16'd10, CLS_RED);
    wait_sv(3);

    stall = 8'h98;
    mdata = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    push_addrs(3);
    err_expected = 1'b1;
    for (int k = 0; k < 4 * P && err_cnt < 1; k++) begin @(negedge clk); #1; end
    chk("error_count", err_cnt, 1);
    stall = 8'h00;
    set_frame(16'd2000, 16'd100, 16'd900, 16'd300, CLS_GREEN);
    wait_sv(4);
    chk("restart_seen", exp_restart, 32'hFFFF_FFFF);

    set_frame(16'd800, 16'd10, 16'd20, 16'd700, CLS_BLUE);
    wait_read(8'h98);
    enable = 1'b0;
    wait_sv(5);
    repeat (P + 20) @(negedge clk);
    #1 chk("disabled_sample_count", sv_cnt, 5);

    push_addrs(2);
    enable = 1'b1;
    wait_read(8'h96);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("mid_rst_start", {31'd0, bus.start}, 32'd0);
    chk("mid_rst_reg_addr", {24'd0, bus.reg_addr}, 32'h94);
    chk("mid_rst_clear", {16'd0, c_o}, 32'd0);
    chk("mid_rst_blue", {16'd0, b_o}, 32'd0);
    chk("mid_rst_class", {30'd0, cls}, 32'd0);
    addr_q.delete();
    set_frame(16'd300, 16'd50, 16'd60, 16'd250, CLS_BLUE);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    wait_sv(6);
    enable = 1'b0;
    repeat (P + 10) @(negedge clk);
    #1;
    chk("frames_left", exp_q.size(), 0);
    chk("reads_left", addr_q.size(), 0);
    chk("error_total", err_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
